// File: rtl/kbd_fifo.sv
// PS/2 keyboard event queue: decodes E0/F0 prefixes, buffers {ext,code} events
// and exposes them to the CPU through four I/O ports plus a level interrupt.
module kbd_fifo #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] PORT_DATA = 8'hFE,
  parameter logic [7:0] PORT_CNT  = 8'hFF,
  parameter logic [7:0] PORT_STAT = 8'hFC,
  parameter logic [7:0] PORT_CTRL = 8'hFD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic [7:0] ps2_ascii,
  input  logic [7:0] port_a,
  input  logic [7:0] port_o,
  input  logic       port_w,
  input  logic       port_r,
  output logic [7:0] port_i,
  output logic       intr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} pfx_t;

  pfx_t          state, state_next;
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          ovf;
  logic [7:0]    ctrl;

  logic       is_ext, is_brk, is_pfx, is_noise, evt;
  logic       push_req, push, pop, overflow, flush, stat_rd;
  logic       empty, full;
  logic [7:0] code;
  logic [8:0] head;

  assign is_ext   = (state == EXT) || (state == EXT_BRK);
  assign is_brk   = (state == BRK) || (state == EXT_BRK);
  assign is_pfx   = (ps2_data == 8'hE0) || (ps2_data == 8'hF0);
  // Controller acknowledge/self-test bytes are only noise outside a prefix
  assign is_noise = (state == IDLE) &&
                    ((ps2_data == 8'hFA) || (ps2_data == 8'hAA) ||
                     (ps2_data == 8'hEE) || (ps2_data == 8'hFE));
  assign evt      = ps2_data_en && !is_pfx && !is_noise;
  assign code     = (ps2_ascii[7:4] == 4'hE) ? ps2_ascii : {is_brk, ps2_ascii[6:0]};

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign flush    = port_w && (port_a == PORT_CTRL) && port_o[7];
  assign stat_rd  = port_r && (port_a == PORT_STAT);
  assign pop      = port_r && (port_a == PORT_DATA) && !empty;
  assign push_req = evt && !(is_brk && !ctrl[0]);
  // A simultaneous pop frees a slot, so a full queue still accepts the push
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else if (ps2_data_en) begin
      if (ps2_data == 8'hE0) begin
        if (state == IDLE)     state_next = EXT;
        else if (state == BRK) state_next = EXT_BRK;
      end else if (ps2_data == 8'hF0) begin
        if (state == IDLE)     state_next = BRK;
        else if (state == EXT) state_next = EXT_BRK;
      end else if (!is_noise) begin
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count + CW'(1);
    else if (pop && !push)  count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ctrl   <= 8'h01;
      intr   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end
      if (flush)         ovf <= 1'b0;
      else if (overflow) ovf <= 1'b1;
      else if (stat_rd)  ovf <= 1'b0;
      if (port_w && (port_a == PORT_CTRL)) ctrl <= {1'b0, port_o[6:0]};
      intr <= ctrl[1] && (count_next != '0);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {is_ext, code};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    if (port_a == PORT_DATA)      port_i = empty ? 8'h00 : head[7:0];
    else if (port_a == PORT_CNT)  port_i = 8'(count);
    else if (port_a == PORT_STAT) port_i = {4'b0, !empty && head[8], ovf, full, !empty};
    else if (port_a == PORT_CTRL) port_i = ctrl;
    else                          port_i = 8'hFF;
  end

endmodule

// File: tb/tb_kbd_fifo.sv
// Bench for kbd_fifo: directed scenarios plus randomized traffic compared
// against a queue-based model of the keyboard event port.
module tb_kbd_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ps2_data, ps2_ascii, port_a, port_o, port_i;
  logic       ps2_data_en, port_w, port_r, intr;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [8:0] q[$];
  bit         m_ext, m_brk, m_ovf, m_intr;
  logic [7:0] m_ctrl;

  kbd_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .ps2_ascii(ps2_ascii), .port_a(port_a), .port_o(port_o), .port_w(port_w),
    .port_r(port_r), .port_i(port_i), .intr(intr)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_intr = 0; m_ctrl = 8'h01;
  endtask

  // One clock edge of the port, applied to the queue model
  task automatic model_clock();
    bit flush, pop, stat_rd, have;
    logic [8:0] ev;
    flush   = port_w && port_a == 8'hFD && port_o[7];
    pop     = port_r && port_a == 8'hFE && q.size() != 0;
    stat_rd = port_r && port_a == 8'hFC;
    have = 0; ev = '0;
    if (ps2_data_en) begin
      if (ps2_data == 8'hE0) m_ext = 1;
      else if (ps2_data == 8'hF0) m_brk = 1;
      else if (!m_ext && !m_brk && (ps2_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) have = 0;
      else begin
        have = !(m_brk && !m_ctrl[0]);
        ev = {m_ext, (ps2_ascii[7:4] == 4'hE) ? ps2_ascii : {m_brk, ps2_ascii[6:0]}};
        m_ext = 0; m_brk = 0;
      end
    end
    if (flush) begin
      q.delete(); m_ovf = 0; m_ext = 0; m_brk = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (stat_rd) m_ovf = 0;
      if (have) begin
        if (q.size() < DEPTH) q.push_back(ev);
        else m_ovf = 1;
      end
    end
    m_intr = m_ctrl[1] && q.size() != 0;
    if (port_w && port_a == 8'hFD) m_ctrl = {1'b0, port_o[6:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    ps2_data_en = 0; port_w = 0; port_r = 0;
  endtask

  task automatic key(input logic [7:0] d, input logic [7:0] a);
    ps2_data = d; ps2_ascii = a; ps2_data_en = 1;
    tick();
  endtask

  task automatic wr_ctrl(input logic [7:0] v);
    port_a = 8'hFD; port_o = v; port_w = 1;
    tick();
  endtask

  task automatic rd_port(input string tag, input logic [7:0] a, input logic [7:0] exp);
    port_a = a; port_r = 0;
    #1 chk(tag, port_i, exp);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    port_a = 8'hFE; port_r = 1;
    #1 chk(tag, port_i, exp);
    tick();
  endtask

  // Compare every readable port and intr against the model
  task automatic peek();
    logic [7:0] e_stat;
    bit ne;
    ne = q.size() != 0;
    e_stat = {4'b0, ne && q[0][8], m_ovf, q.size() == DEPTH, ne};
    rd_port("data", 8'hFE, ne ? q[0][7:0] : 8'h00);
    rd_port("cnt", 8'hFF, 8'(q.size()));
    rd_port("stat", 8'hFC, e_stat);
    rd_port("ctrl", 8'hFD, m_ctrl);
    rd_port("other", 8'h10, 8'hFF);
    chk("intr", intr, m_intr);
  endtask

  initial begin
    reset_n = 0; ps2_data = 0; ps2_data_en = 0; ps2_ascii = 0;
    port_a = 0; port_o = 0; port_w = 0; port_r = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;

    rd_port("rst_stat", 8'hFC, 8'h00);
    rd_port("rst_cnt", 8'hFF, 8'h00);
    rd_port("rst_ctrl", 8'hFD, 8'h01);
    chk("rst_intr", intr, 1'b0);

    // Press and release of 'a'
    key(8'h1C, 8'h61); key(8'hF0, 8'h00); key(8'h1C, 8'h61);
    rd_port("ab_cnt", 8'hFF, 8'h02);
    pop_chk("ab_pop1", 8'h61);
    pop_chk("ab_pop2", 8'hE1);
    pop_chk("ab_pop3", 8'h00);
    peek();

    // Extended key, then release suppression
    key(8'hE0, 8'h00); key(8'h75, 8'hE5);
    rd_port("ext_stat", 8'hFC, 8'h09);
    pop_chk("ext_data", 8'hE5);
    wr_ctrl(8'h00);
    key(8'hF0, 8'h00); key(8'h1C, 8'h61);
    rd_port("norel_cnt", 8'hFF, 8'h00);
    wr_ctrl(8'h01);
    peek();

    // Overflow: 17 presses into 16 slots
    for (int i = 0; i < 17; i++) key(8'h16, 8'h30 + 8'(i));
    rd_port("full_cnt", 8'hFF, 8'h10);
    rd_port("full_stat", 8'hFC, 8'h07);
    port_a = 8'hFC; port_r = 1; tick();
    rd_port("ovfclr_stat", 8'hFC, 8'h03);

    // Full queue: push and pop in the same cycle is not an overflow
    port_a = 8'hFE; port_r = 1;
    ps2_data = 8'h16; ps2_ascii = 8'h50; ps2_data_en = 1;
    #1 chk("pp_head", port_i, 8'h30);
    tick();
    rd_port("pp_cnt", 8'hFF, 8'h10);
    rd_port("pp_stat", 8'hFC, 8'h03);
    for (int i = 1; i < 16; i++) pop_chk("order", 8'h30 + 8'(i));
    pop_chk("pp_tail", 8'h50);
    peek();

    // Interrupt and flush
    wr_ctrl(8'h02);
    key(8'h1C, 8'h61);
    chk("irq_on", intr, 1'b1);
    wr_ctrl(8'h82);
    rd_port("flush_cnt", 8'hFF, 8'h00);
    rd_port("flush_stat", 8'hFC, 8'h00);
    rd_port("flush_ctrl", 8'hFD, 8'h02);
    chk("irq_off", intr, 1'b0);
    peek();

    // Async reset between prefix and code drops the prefix
    key(8'hE0, 8'h00);
    reset_n = 0; model_reset();
    #3 reset_n = 1;
    key(8'h75, 8'hE5);
    rd_port("arst_stat", 8'hFC, 8'h01);
    rd_port("arst_data", 8'hFE, 8'hE5);
    peek();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int sel;
      peek();
      sel = $urandom_range(0, 9);
      case (sel)
        0: ps2_data = 8'hE0;
        1: ps2_data = 8'hF0;
        2: begin
          logic [7:0] nz [4] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE};
          ps2_data = nz[$urandom_range(0, 3)];
        end
        default: ps2_data = 8'($urandom);
      endcase
      ps2_data_en = ($urandom_range(0, 1) == 1);
      ps2_ascii = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ps2_ascii[7:4] = 4'hE;
      case ($urandom_range(0, 5))
        0, 1:    port_a = 8'hFE;
        2:       port_a = 8'hFF;
        3:       port_a = 8'hFC;
        4:       port_a = 8'hFD;
        default: port_a = 8'($urandom);
      endcase
      port_r = ($urandom_range(0, 2) == 0);
      port_w = ($urandom_range(0, 7) == 0);
      port_o = 8'($urandom) & 8'h7F;
      if ($urandom_range(0, 7) == 0) port_o[7] = 1'b1;
      tick();
    end
    peek();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
